hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. It sits beside the decode/execute datapath and takes stage register addresses and control bits (RegWrite, MemtoReg, MemWrite, branch-taken) from the D/E/M/W pipeline registers. It drives operand forwarding selects, stage stall/flush enables, and a data-memory wait FSM with timeout. All stall/flush decisions are centralised here; the datapath only obeys them.

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/hazard_fwd_unit.sv | 26 ++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forwarding-select encodings, memory-wait FSM states and the default timeout.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int MEM_TIMEOUT_DEF = 16;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } memState_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding compare for one E-stage source register.
// The M-stage result is younger than the W-stage result, so it has priority.
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    output logic [1:0]            Forward
);

    // NOTE: assign a default before any branch so no path leaves Forward unassigned (latch).
    always_comb begin
        Forward = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == RsE)) begin
            Forward = FWD_M;
        end else if (RegWriteW && (RdW != '0) && (RdW == RsE)) begin
            Forward = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, stall/flush priority and data-memory wait FSM.
// Optional performance counters are built only when HAZ_PERF_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  MemtoRegE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemWriteM,
    input  logic                  MemtoRegM,
    input  logic                  PCSrcE,
    input  logic                  dmem_ready,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  mem_timeout,
    output logic                  mem_err,
    output logic [31:0]           perf_stall,
    output logic [31:0]           perf_flush,
    output logic [31:0]           perf_memwait
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    memState_t        state;
    logic [CNT_W-1:0] cnt;
    logic             memM;
    logic             memStall;
    logic             memRelease;
    logic             loadUse;
    logic             luStall;
    logic             brFlush;

    hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwdA (
        .RsE       (Rs1E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Forward   (ForwardAE)
    );

    hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwdB (
        .RsE       (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Forward   (ForwardBE)
    );

    assign memM = MemWriteM | MemtoRegM;

    // A vanished memory op while waiting is treated like a completed access.
    always_comb begin
        memStall   = 1'b0;
        memRelease = 1'b0;
        case (state)
            RUN: begin
                memStall = memM && !dmem_ready;
            end
            WAIT: begin
                if (memM && !dmem_ready) begin
                    if (cnt == TIMEOUT_CNT) begin
                        memRelease = 1'b1;
                    end else begin
                        memStall = 1'b1;
                    end
                end
            end
            default: begin
                memStall = 1'b0;
            end
        endcase
    end

    assign loadUse = MemtoRegE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Memory stall overrides everything; a taken branch discards the load-use consumer.
    assign brFlush = !memStall && PCSrcE;
    assign luStall = !memStall && !PCSrcE && loadUse;

    assign StallF      = memStall | luStall;
    assign StallD      = memStall | luStall;
    assign StallE      = memStall;
    assign StallM      = memStall;
    assign FlushD      = brFlush;
    assign FlushE      = brFlush | luStall;
    assign FlushW      = memStall;
    assign mem_timeout = memRelease;

    // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memM && !dmem_ready) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!memM || dmem_ready) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_CNT) begin
                        state   <= RUN;
                        cnt     <= '0;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall   <= '0;
            perf_flush   <= '0;
            perf_memwait <= '0;
        end else begin
            if (luStall)  perf_stall   <= perf_stall + 32'd1;
            if (brFlush)  perf_flush   <= perf_flush + 32'd1;
            if (memStall) perf_memwait <= perf_memwait + 32'd1;
        end
    end
`else
    assign perf_stall   = '0;
    assign perf_flush   = '0;
    assign perf_memwait = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       MemtoRegE, RegWriteM, RegWriteW, MemWriteM, MemtoRegM, PCSrcE, dmem_ready;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic       mem_timeout, mem_err;
    logic [31:0] perf_stall, perf_flush, perf_memwait;

    int checks = 0;
    int errors = 0;
    bit driverDone = 1'b0;

    typedef struct {
        string      name;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] stl;
        logic [2:0] fl;
        logic       to;
        logic       err;
        bit         perfChk;
    } exp_t;

    exp_t sb[$];

    hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rs1D         (Rs1D),
        .Rs2D         (Rs2D),
        .Rs1E         (Rs1E),
        .Rs2E         (Rs2E),
        .RdE          (RdE),
        .RdM          (RdM),
        .RdW          (RdW),
        .MemtoRegE    (MemtoRegE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemWriteM    (MemWriteM),
        .MemtoRegM    (MemtoRegM),
        .PCSrcE       (PCSrcE),
        .dmem_ready   (dmem_ready),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .mem_timeout  (mem_timeout),
        .mem_err      (mem_err),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush),
        .perf_memwait (perf_memwait)
    );

    always #5 clk = ~clk;

    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        MemtoRegE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemWriteM = 1'b0; MemtoRegM = 1'b0; PCSrcE = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input string n, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [3:0] stl, input logic [2:0] fl,
                        input logic to, input logic err, input bit pc = 1'b0);
        exp_t e;
        e.name = n; e.fa = fa; e.fb = fb; e.stl = stl; e.fl = fl;
        e.to = to; e.err = err; e.perfChk = pc;
        sb.push_back(e);
    endtask

    // Monitor: every cycle with a pending expectation is compared at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [12:0] got, want;
            e = sb.pop_front();
            got  = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                    FlushD, FlushE, FlushW, mem_timeout, mem_err};
            want = {e.fa, e.fb, e.stl, e.fl, e.to, e.err};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got fa/fb/stlFDEM/flDEW/to/err=%b expected %b", e.name, got, want);
            end
`ifdef HAZ_PERF_EN
            if (e.perfChk) begin
                checks++;
                if (perf_memwait !== 32'd0) begin
                    errors++;
                    $display("FAIL %s_perf_memwait: got %0d expected 0", e.name, perf_memwait);
                end
            end
`else
            checks++;
            if ({perf_stall, perf_flush, perf_memwait} !== 96'd0) begin
                errors++;
                $display("FAIL %s_perf_tied: got %h/%h/%h expected all 0", e.name,
                         perf_stall, perf_flush, perf_memwait);
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        idle();
        nextCycle();
        push("reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b1);
        nextCycle();
        rst_n = 1'b1;

        // Forwarding priority
        nextCycle();
        RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
        push("fwd_m_beats_w", 2'b10, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);
        nextCycle();
        RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 0; RegWriteW = 1;
        push("fwd_w_only", 2'b01, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);
        nextCycle();
        RdM = 0; RdW = 0; Rs1E = 0; RegWriteM = 1; RegWriteW = 1;
        push("fwd_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);
        nextCycle();
        RdM = 3; RdW = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1;
        push("fwd_b_w", 2'b00, 2'b01, 4'b0000, 3'b000, 1'b0, 1'b0);

        // Load-use then forward from M
        nextCycle();
        MemtoRegE = 1; RdE = 7; Rs2D = 7;
        push("load_use", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, 1'b0);
        nextCycle();
        RdM = 7; RegWriteM = 1; MemtoRegM = 1; dmem_ready = 1; Rs2E = 7;
        push("load_in_m_fwd", 2'b00, 2'b10, 4'b0000, 3'b000, 1'b0, 1'b0);

        // Branch vs load-use, plain branch, x0 load-use
        nextCycle();
        MemtoRegE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
        push("branch_beats_lu", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, 1'b0);
        nextCycle();
        PCSrcE = 1;
        push("branch_only", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, 1'b0);
        nextCycle();
        MemtoRegE = 1; RdE = 0; Rs1D = 0;
        push("lu_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);

        // Memory wait: three slow cycles, branch and load-use suppressed meanwhile
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            MemtoRegM = 1; MemtoRegE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
            push($sformatf("memwait_%0d", i), 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b0);
        end
        nextCycle();
        MemtoRegM = 1; dmem_ready = 1;
        push("memwait_ready", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);

        // Timeout at MEM_TIMEOUT=4
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            MemWriteM = 1;
            push($sformatf("to_stall_%0d", i), 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b0);
        end
        nextCycle();
        MemWriteM = 1;
        push("to_release", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b0);
        nextCycle();
        push("to_err_set", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);
        nextCycle();
        push("to_err_sticky", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);
        nextCycle();
        rst_n = 1'b0;
        push("rst_clears_err", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b1);
        nextCycle();
        rst_n = 1'b1;

        // Reset in the middle of a wait, then a full timeout from a fresh counter
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            MemtoRegM = 1;
            push($sformatf("mid_wait_%0d", i), 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b0);
        end
        nextCycle();
        rst_n = 1'b0;
        push("mid_wait_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b1);
        nextCycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            MemtoRegM = 1;
            push($sformatf("post_rst_stall_%0d", i), 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b0);
        end
        nextCycle();
        MemtoRegM = 1;
        push("post_rst_release", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b0);
        nextCycle();
        push("post_rst_err", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
